// File: rtl/smpl_dmem_arbiter.sv
`timescale 1ns/1ps
// Two-port data-memory arbiter (core port A, loader/debug port B) in front of a single-port RAM.
// Latency: grant is combinational in the request cycle; read data returns one cycle after the grant.
// Backpressure: a low x_gnt stalls that requester, which holds its request; nothing is buffered here.
module smpl_dmem_arbiter #(
    parameter int AW       = 13,
    parameter int DW       = 16,
    parameter int MAX_LOCK = 8
) (
    input  logic          clock,
    input  logic          reset,

    input  logic          a_req,
    input  logic          a_we,
    input  logic          a_lock,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_gnt,
    output logic          a_rvalid,
    output logic [DW-1:0] a_rdata,

    input  logic          b_req,
    input  logic          b_we,
    input  logic          b_lock,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_gnt,
    output logic          b_rvalid,
    output logic [DW-1:0] b_rdata,

    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        LOCK_A = 2'd1,
        LOCK_B = 2'd2
    } state_t;

    localparam logic       LAST_A  = 1'b0;
    localparam logic       LAST_B  = 1'b1;
    localparam logic [7:0] MAX_CNT = 8'(MAX_LOCK);
    // A limit of one grant means a lock can never outlive its first grant.
    localparam bit         LOCK_OK = (MAX_LOCK > 1);

    state_t       state_q, state_d;
    logic         last_q, last_d;
    logic [7:0]   cnt_q, cnt_d;
    logic [7:0]   cnt_inc;
    logic         a_rv_q, b_rv_q;

    assign cnt_inc = cnt_q + 8'd1;

    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (!reset) begin
            case (state_q)
                LOCK_A: a_gnt = a_req;
                LOCK_B: b_gnt = b_req;
                default: begin
                    if (a_req && b_req) begin
                        a_gnt = (last_q == LAST_B);
                        b_gnt = (last_q == LAST_A);
                    end else begin
                        a_gnt = a_req;
                        b_gnt = b_req;
                    end
                end
            endcase
        end
    end

    always_comb begin
        mem_en    = a_gnt | b_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (a_gnt) begin
            mem_we    = a_we;
            mem_addr  = a_addr;
            mem_wdata = a_wdata;
        end else if (b_gnt) begin
            mem_we    = b_we;
            mem_addr  = b_addr;
            mem_wdata = b_wdata;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        if (a_gnt) last_d = LAST_A;
        if (b_gnt) last_d = LAST_B;
        case (state_q)
            LOCK_A: begin
                if (!a_lock) begin
                    state_d = FREE;
                    cnt_d   = '0;
                end else if (a_gnt) begin
                    if (cnt_inc == MAX_CNT) begin
                        state_d = FREE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            LOCK_B: begin
                if (!b_lock) begin
                    state_d = FREE;
                    cnt_d   = '0;
                end else if (b_gnt) begin
                    if (cnt_inc == MAX_CNT) begin
                        state_d = FREE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            default: begin
                if (LOCK_OK && a_gnt && a_lock) begin
                    state_d = LOCK_A;
                    cnt_d   = 8'd1;
                end else if (LOCK_OK && b_gnt && b_lock) begin
                    state_d = LOCK_B;
                    cnt_d   = 8'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= FREE;
            last_q  <= LAST_B;
            cnt_q   <= '0;
            a_rv_q  <= 1'b0;
            b_rv_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            a_rv_q  <= a_gnt & ~a_we;
            b_rv_q  <= b_gnt & ~b_we;
        end
    end

    // Gated by reset so a read in flight when reset hits never surfaces.
    assign a_rvalid = a_rv_q & ~reset;
    assign b_rvalid = b_rv_q & ~reset;
    assign a_rdata  = a_rvalid ? mem_rdata : '0;
    assign b_rdata  = b_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_smpl_dmem_arbiter.sv
`timescale 1ns/1ps
// Self-checking bench for smpl_dmem_arbiter: directed scenarios plus random traffic,
// compared every cycle against a behavioural model with a reference memory.
module tb_smpl_dmem_arbiter;

    localparam int AW       = 13;
    localparam int DW       = 16;
    localparam int MAX_LOCK = 8;
    localparam int VW       = 4 + AW + DW + 2 + 2 * DW;

    logic          clock = 1'b0;
    logic          reset;
    logic          a_req, a_we, a_lock, b_req, b_we, b_lock;
    logic [AW-1:0] a_addr, b_addr, mem_addr;
    logic [DW-1:0] a_wdata, b_wdata, a_rdata, b_rdata, mem_wdata, mem_rdata;
    logic          a_gnt, b_gnt, a_rvalid, b_rvalid, mem_en, mem_we;

    always #5 clock = ~clock;

    smpl_dmem_arbiter #(.AW(AW), .DW(DW), .MAX_LOCK(MAX_LOCK)) dut (
        .clock(clock), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_lock(a_lock), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_lock(b_lock), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Single-port RAM with one-cycle read latency, 16 words (address low bits).
    logic [DW-1:0] ram [0:15] = '{default: '0};
    logic [DW-1:0] ram_q = '0;
    always @(posedge clock) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr[3:0]] <= mem_wdata;
            else        ram_q <= ram[mem_addr[3:0]];
        end
    end
    assign mem_rdata = ram_q;

    // Reference model: who holds the memory, how many locked grants so far, last winner.
    logic [DW-1:0] ref_mem [0:15] = '{default: '0};
    int            m_holder = -1;
    int            m_run    = 0;
    bit            m_last   = 1'b1;
    bit            p_a = 1'b0, p_b = 1'b0;
    logic [DW-1:0] p_dat = '0;
    bit            e_ag, e_bg;
    logic [VW-1:0] exp_vec;
    int            errors = 0;
    int            checks = 0;

    function automatic logic [VW-1:0] obs();
        return {a_gnt, b_gnt, mem_en, mem_we, mem_addr, mem_wdata, a_rvalid, b_rvalid, a_rdata, b_rdata};
    endfunction

    task automatic model_eval();
        logic          ewe;
        logic [AW-1:0] ead;
        logic [DW-1:0] ewd;
        e_ag = 1'b0; e_bg = 1'b0; ewe = 1'b0; ead = '0; ewd = '0;
        if (!reset) begin
            if (m_holder == 0)            e_ag = a_req;
            else if (m_holder == 1)       e_bg = b_req;
            else if (a_req && b_req) begin
                e_ag = m_last;
                e_bg = !m_last;
            end else begin
                e_ag = a_req;
                e_bg = b_req;
            end
        end
        if (e_ag)      begin ewe = a_we; ead = a_addr; ewd = a_wdata; end
        else if (e_bg) begin ewe = b_we; ead = b_addr; ewd = b_wdata; end
        exp_vec = {e_ag, e_bg, e_ag | e_bg, ewe, ead, ewd,
                   !reset && p_a, !reset && p_b,
                   (!reset && p_a) ? p_dat : {DW{1'b0}},
                   (!reset && p_b) ? p_dat : {DW{1'b0}}};
    endtask

    task automatic model_commit();
        int w;
        bit wl, hl;
        if (reset) begin
            m_holder = -1; m_run = 0; m_last = 1'b1; p_a = 1'b0; p_b = 1'b0;
            return;
        end
        w   = e_ag ? 0 : (e_bg ? 1 : -1);
        p_a = e_ag && !a_we;
        p_b = e_bg && !b_we;
        if (e_ag) begin
            if (a_we) ref_mem[a_addr[3:0]] = a_wdata;
            else      p_dat = ref_mem[a_addr[3:0]];
        end
        if (e_bg) begin
            if (b_we) ref_mem[b_addr[3:0]] = b_wdata;
            else      p_dat = ref_mem[b_addr[3:0]];
        end
        if (w >= 0) m_last = (w == 1);
        wl = (w == 0) ? a_lock : b_lock;
        if (m_holder < 0) begin
            if (w >= 0 && wl) begin
                m_run = 1;
                if (m_run < MAX_LOCK) m_holder = w;
            end
        end else begin
            hl = (m_holder == 0) ? a_lock : b_lock;
            if (!hl) m_holder = -1;
            else if (w == m_holder) begin
                m_run++;
                if (m_run >= MAX_LOCK) m_holder = -1;
            end
        end
    endtask

    task automatic apply(input bit ar, input bit aw, input bit al, input int aa, input logic [DW-1:0] ad,
                         input bit br, input bit bw, input bit bl, input int ba, input logic [DW-1:0] bd);
        a_req = ar; a_we = aw; a_lock = al; a_addr = AW'(aa); a_wdata = ad;
        b_req = br; b_we = bw; b_lock = bl; b_addr = AW'(ba); b_wdata = bd;
    endtask

    task automatic idle();
        apply(1'b0, 1'b0, 1'b0, 0, '0, 1'b0, 1'b0, 1'b0, 0, '0);
    endtask

    task automatic adv();
        @(posedge clock);
        model_commit();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        repeat (2) begin
            @(negedge clock);
            model_eval();
            adv();
        end
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            apply(1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 15), 16'($urandom),
                  1'b1, 1'($urandom), 1'($urandom), $urandom_range(0, 15), 16'($urandom));
            @(negedge clock);
            model_eval();
            checks++;
            if (obs() !== {VW{1'b0}}) begin
                errors++;
                $display("FAIL reset_outputs cyc%0d: got %h expected all zero", i, obs());
            end
            adv();
        end
        reset = 1'b0;
        apply(1'b1, 1'b0, 1'b0, 2, '0, 1'b0, 1'b0, 1'b0, 0, '0);
        @(negedge clock);
        model_eval();
        checks++;
        if (a_gnt !== 1'b1 || mem_addr !== AW'(2)) begin
            errors++;
            $display("FAIL first_grant: got gnt=%b addr=%0d expected gnt=1 addr=2", a_gnt, mem_addr);
        end
        adv();
        idle();
    endtask

    task automatic test_tie();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            if (i < 4) apply(1'b1, 1'b0, 1'b0, 5, '0, 1'b1, 1'b0, 1'b0, 9, '0);
            else       idle();
            @(negedge clock);
            model_eval();
            checks++;
            if (obs() !== exp_vec) begin
                errors++;
                $display("FAIL tie_model cyc%0d: got %h expected %h", i, obs(), exp_vec);
            end
            if (i < 4) begin
                checks++;
                if ({a_gnt, b_gnt} !== ((i % 2 == 0) ? 2'b10 : 2'b01) || mem_addr !== AW'((i % 2 == 0) ? 5 : 9)) begin
                    errors++;
                    $display("FAIL tie_order cyc%0d: got gnt=%b%b addr=%0d", i, a_gnt, b_gnt, mem_addr);
                end
            end
            if (i > 0) begin
                checks++;
                if ({a_rvalid, b_rvalid} !== ((i % 2 == 1) ? 2'b10 : 2'b01)) begin
                    errors++;
                    $display("FAIL tie_rvalid cyc%0d: got %b%b", i, a_rvalid, b_rvalid);
                end
            end
            adv();
        end
    endtask

    task automatic test_read_after_write();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            case (i)
                0:       apply(1'b0, 1'b0, 1'b0, 0, '0, 1'b1, 1'b1, 1'b0, 3, 16'h1234);
                1:       apply(1'b1, 1'b0, 1'b0, 3, '0, 1'b0, 1'b0, 1'b0, 0, '0);
                default: idle();
            endcase
            @(negedge clock);
            model_eval();
            checks++;
            if (obs() !== exp_vec) begin
                errors++;
                $display("FAIL raw_model cyc%0d: got %h expected %h", i, obs(), exp_vec);
            end
            if (i == 2) begin
                checks++;
                if (a_rvalid !== 1'b1 || a_rdata !== 16'h1234) begin
                    errors++;
                    $display("FAIL raw_data: got rvalid=%b rdata=%h expected 1 1234", a_rvalid, a_rdata);
                end
            end
            adv();
        end
    endtask

    task automatic test_lock();
        do_reset();
        for (int i = 0; i < 7; i++) begin
            if (i == 0)      apply(1'b1, 1'b0, 1'b0, 1, '0, 1'b0, 1'b0, 1'b0, 0, '0);
            else if (i <= 4) apply(1'b1, 1'b0, 1'b0, 2, '0, 1'b1, 1'b0, 1'b1, 4, '0);
            else             apply(1'b1, 1'b0, 1'b0, 2, '0, 1'b0, 1'b0, 1'b0, 4, '0);
            @(negedge clock);
            model_eval();
            checks++;
            if (obs() !== exp_vec) begin
                errors++;
                $display("FAIL lock_model cyc%0d: got %h expected %h", i, obs(), exp_vec);
            end
            if (i >= 1) begin
                checks++;
                if ({a_gnt, b_gnt} !== ((i <= 4) ? 2'b01 : ((i == 5) ? 2'b00 : 2'b10))) begin
                    errors++;
                    $display("FAIL lock_gnt cyc%0d: got %b%b", i, a_gnt, b_gnt);
                end
            end
            adv();
        end
        idle();
    endtask

    task automatic test_starvation();
        int nb;
        int first_a;
        do_reset();
        nb = 0;
        first_a = -1;
        apply(1'b1, 1'b0, 1'b0, 0, '0, 1'b0, 1'b0, 1'b0, 0, '0);
        @(negedge clock);
        model_eval();
        adv();
        for (int i = 0; i < 12; i++) begin
            apply(1'b1, 1'b0, 1'b0, 6, '0, 1'b1, 1'b0, 1'b1, 7, '0);
            @(negedge clock);
            model_eval();
            checks++;
            if (obs() !== exp_vec) begin
                errors++;
                $display("FAIL starve_model cyc%0d: got %h expected %h", i, obs(), exp_vec);
            end
            if (a_gnt === 1'b1 && first_a < 0) first_a = i;
            if (b_gnt === 1'b1 && first_a < 0) nb++;
            adv();
        end
        checks++;
        if (nb != MAX_LOCK || first_a != MAX_LOCK) begin
            errors++;
            $display("FAIL starve_limit: got b_grants=%0d first_a=%0d expected %0d %0d", nb, first_a, MAX_LOCK, MAX_LOCK);
        end
        idle();
    endtask

    task automatic test_reset_mid_lock();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: apply(1'b0, 1'b0, 1'b0, 0, '0, 1'b1, 1'b0, 1'b1, 3, '0);
                1: begin
                    reset = 1'b1;
                    apply(1'b1, 1'b0, 1'b0, 4, '0, 1'b1, 1'b0, 1'b1, 3, '0);
                end
                2: begin
                    reset = 1'b0;
                    apply(1'b1, 1'b0, 1'b0, 4, '0, 1'b0, 1'b0, 1'b0, 0, '0);
                end
                default: idle();
            endcase
            @(negedge clock);
            model_eval();
            checks++;
            if (obs() !== exp_vec) begin
                errors++;
                $display("FAIL rstlock_model cyc%0d: got %h expected %h", i, obs(), exp_vec);
            end
            if (i == 1) begin
                checks++;
                if (obs() !== {VW{1'b0}}) begin
                    errors++;
                    $display("FAIL rstlock_zero: got %h expected all zero", obs());
                end
            end
            if (i >= 2) begin
                checks++;
                if (b_rvalid !== 1'b0 || (i == 2 && a_gnt !== 1'b1) || (i == 3 && a_rvalid !== 1'b1)) begin
                    errors++;
                    $display("FAIL rstlock_after cyc%0d: got a_gnt=%b a_rvalid=%b b_rvalid=%b", i, a_gnt, a_rvalid, b_rvalid);
                end
            end
            adv();
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 59) == 0);
            apply(1'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0), $urandom_range(0, 7), 16'($urandom),
                  1'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0), $urandom_range(0, 7), 16'($urandom));
            @(negedge clock);
            model_eval();
            checks++;
            if (obs() !== exp_vec) begin
                errors++;
                $display("FAIL random_model cyc%0d: got %h expected %h", i, obs(), exp_vec);
            end
            checks++;
            if ((a_gnt && b_gnt) || (a_gnt && !a_req) || (b_gnt && !b_req)) begin
                errors++;
                $display("FAIL random_grant cyc%0d: got gnt=%b%b req=%b%b", i, a_gnt, b_gnt, a_req, b_req);
            end
            adv();
        end
        reset = 1'b0;
        idle();
    endtask

    initial begin
        reset = 1'b1;
        idle();
        test_reset();
        test_tie();
        test_read_after_write();
        test_lock();
        test_starvation();
        test_reset_mid_lock();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
